// File: rtl/fechadura_pkg.sv
// Shared types and constants for the controle_fechadura lock controller:
// FSM state encoding, default password and the timer width helper.
package fechadura_pkg;

    typedef enum logic [1:0] {
        FECHADO  = 2'd0,
        ABERTO   = 2'd1,
        BLOQUEIO = 2'd2
    } estado_t;

    localparam logic [5:0] SENHA_INICIAL_DEF = 6'b101010;

    // Wide enough to hold max(T_ABERTO, T_BLOQUEIO) - 1; never narrower than one bit.
    function automatic int largura_timer(input int unsigned a, input int unsigned b);
        int unsigned m;
        int          w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/controle_fechadura_temporizador.sv
// Down-counter for controle_fechadura: loads a value, counts down to zero
// and then holds at zero until the next load.
module temporizador #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_valor,
    output logic         o_zero
);

    logic [W-1:0] r_valor;

    // Countdown register: load wins, otherwise decrement and saturate at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valor <= '0;
        end else if (i_load) begin
            r_valor <= i_valor;
        end else if (r_valor != '0) begin
            r_valor <= r_valor - W'(1);
        end else begin
            r_valor <= r_valor;
        end
    end

    assign o_zero = (r_valor == '0);

endmodule

// File: rtl/controle_fechadura.sv
// Electronic lock controller: opens on a correct password, counts wrong attempts
// and locks out after MAX_TENTATIVAS. Optional macro PASSWORD_CHANGE_EN enables
// changing the stored password with a trocar_btn rising edge while open.
module controle_fechadura
    import fechadura_pkg::*;
#(
    parameter int unsigned MAX_TENTATIVAS = 3,
    parameter int unsigned T_ABERTO       = 50_000_000,
    parameter int unsigned T_BLOQUEIO     = 250_000_000,
    parameter logic [5:0]  SENHA_INICIAL  = SENHA_INICIAL_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       senha_correta,
    input  logic       senha_errada,
    input  logic       trocar_btn,
    input  logic [5:0] senha_nova,
    output logic [5:0] senha_ref,
    output logic       aberto,
    output logic       bloqueado,
    output logic [2:0] erros
);

    localparam int TW = largura_timer(T_ABERTO, T_BLOQUEIO);

    estado_t       r_estado;
    logic          r_aberto;
    logic          r_bloqueado;
    logic [2:0]    r_erros;
    logic [3:0]    w_erros_inc;
    logic          w_limite;
    logic          w_load;
    logic [TW-1:0] w_load_valor;
    logic          w_zero;

    assign w_erros_inc = {1'b0, r_erros} + 4'd1;
    assign w_limite    = (w_erros_inc >= 4'(MAX_TENTATIVAS));

    // Timer reload: only on entry to ABERTO or BLOQUEIO; a simultaneous pair counts as wrong.
    always_comb begin
        w_load       = 1'b0;
        w_load_valor = '0;
        case (r_estado)
            FECHADO: begin
                if (senha_errada && w_limite) begin
                    w_load       = 1'b1;
                    w_load_valor = TW'(T_BLOQUEIO - 1);
                end else if (!senha_errada && senha_correta) begin
                    w_load       = 1'b1;
                    w_load_valor = TW'(T_ABERTO - 1);
                end else begin
                    w_load       = 1'b0;
                    w_load_valor = '0;
                end
            end
            default: begin
                w_load       = 1'b0;
                w_load_valor = '0;
            end
        endcase
    end

    temporizador #(
        .W(TW)
    ) u_temporizador (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_valor (w_load_valor),
        .o_zero  (w_zero)
    );

    // Lock FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado    <= FECHADO;
            r_aberto    <= 1'b0;
            r_bloqueado <= 1'b0;
            r_erros     <= 3'd0;
        end else begin
            case (r_estado)
                FECHADO: begin
                    if (senha_errada) begin
                        if (w_limite) begin
                            r_estado    <= BLOQUEIO;
                            r_bloqueado <= 1'b1;
                            r_erros     <= 3'(MAX_TENTATIVAS);
                        end else begin
                            r_erros <= w_erros_inc[2:0];
                        end
                    end else if (senha_correta) begin
                        r_estado <= ABERTO;
                        r_aberto <= 1'b1;
                        r_erros  <= 3'd0;
                    end else begin
                        r_estado <= FECHADO;
                    end
                end
                ABERTO: begin
                    if (w_zero) begin
                        r_estado <= FECHADO;
                        r_aberto <= 1'b0;
                    end else begin
                        r_estado <= ABERTO;
                    end
                end
                BLOQUEIO: begin
                    if (w_zero) begin
                        r_estado    <= FECHADO;
                        r_bloqueado <= 1'b0;
                        r_erros     <= 3'd0;
                    end else begin
                        r_estado <= BLOQUEIO;
                    end
                end
                default: begin
                    r_estado    <= FECHADO;
                    r_aberto    <= 1'b0;
                    r_bloqueado <= 1'b0;
                    r_erros     <= 3'd0;
                end
            endcase
        end
    end

    assign aberto    = r_aberto;
    assign bloqueado = r_bloqueado;
    assign erros     = r_erros;

`ifdef PASSWORD_CHANGE_EN
    logic       r_trocar_ant;
    logic [5:0] r_senha_ref;
    logic       w_borda;

    assign w_borda = trocar_btn & ~r_trocar_ant;

    // Button edge history and stored password; change accepted only while open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trocar_ant <= 1'b0;
            r_senha_ref  <= SENHA_INICIAL;
        end else begin
            r_trocar_ant <= trocar_btn;
            if (w_borda && (r_estado == ABERTO)) begin
                r_senha_ref <= senha_nova;
            end else begin
                r_senha_ref <= r_senha_ref;
            end
        end
    end

    assign senha_ref = r_senha_ref;
`else
    logic w_unused_entradas;

    assign w_unused_entradas = ^{trocar_btn, senha_nova};
    assign senha_ref         = SENHA_INICIAL;
`endif

endmodule

// File: tb/tb_controle_fechadura.sv
// Self-checking bench for controle_fechadura (MAX_TENTATIVAS=3, T_ABERTO=5, T_BLOQUEIO=8):
// directed scenarios with literal expectations plus randomized traffic against a behavioural model.
module tb_controle_fechadura;

    localparam int MAXT = 3;
    localparam int TA   = 5;
    localparam int TB   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       correta = 1'b0;
    logic       errada = 1'b0;
    logic       trocar = 1'b0;
    logic [5:0] nova = 6'd0;
    logic [5:0] senha_ref;
    logic       aberto;
    logic       bloqueado;
    logic [2:0] erros;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         cmp_en   = 1'b0;

    // Model: remaining open/lock cycles, error count, stored password
    int         m_open;
    int         m_lock;
    int         m_erros;
    logic [5:0] m_senha;
`ifdef PASSWORD_CHANGE_EN
    bit         m_prev;
`endif

    controle_fechadura #(
        .MAX_TENTATIVAS(MAXT),
        .T_ABERTO(TA),
        .T_BLOQUEIO(TB),
        .SENHA_INICIAL(6'b101010)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .senha_correta (correta),
        .senha_errada  (errada),
        .trocar_btn    (trocar),
        .senha_nova    (nova),
        .senha_ref     (senha_ref),
        .aberto        (aberto),
        .bloqueado     (bloqueado),
        .erros         (erros)
    );

    always #5 clk = ~clk;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open  = 0;
        m_lock  = 0;
        m_erros = 0;
        m_senha = 6'b101010;
`ifdef PASSWORD_CHANGE_EN
        m_prev  = 1'b0;
`endif
    endtask

    task automatic model_step(input bit c, input bit e, input bit t, input logic [5:0] n);
`ifdef PASSWORD_CHANGE_EN
        bit edge_t;
        edge_t = t && !m_prev;
        m_prev = t;
`endif
        if (m_open > 0) begin
`ifdef PASSWORD_CHANGE_EN
            if (edge_t) m_senha = n;
`endif
            m_open--;
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_erros = 0;
        end else if (e) begin
            m_erros++;
            if (m_erros == MAXT) m_lock = TB;
        end else if (c) begin
            m_open  = TA;
            m_erros = 0;
        end
    endtask

    // One clock cycle: apply inputs, let the edge happen, advance the model.
    task automatic cycle(input bit r, input bit c, input bit e, input bit t, input logic [5:0] n);
        rst_n   = r;
        correta = c;
        errada  = e;
        trocar  = t;
        nova    = n;
        if (!r) model_reset();
        @(posedge clk);
        if (r) model_step(c, e, t, n);
        #2;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("aberto", {31'd0, aberto}, {31'd0, (m_open > 0)});
            check("bloqueado", {31'd0, bloqueado}, {31'd0, (m_lock > 0)});
            check("erros", {29'd0, erros}, m_erros);
            check("senha_ref", {26'd0, senha_ref}, {26'd0, m_senha});
            check("exclusivo", {31'd0, (aberto & bloqueado)}, 32'd0);
        end
    end

    initial begin
        model_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        cmp_en = 1'b1;
        check("rst_aberto", {31'd0, aberto}, 32'd0);
        check("rst_bloqueado", {31'd0, bloqueado}, 32'd0);
        check("rst_erros", {29'd0, erros}, 32'd0);
        check("rst_senha", {26'd0, senha_ref}, 32'h2A);

        // Correct pulse at cycle 10 -> open 11..15
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        check("open_c11", {31'd0, aberto}, 32'd1);
        check("open_erros", {29'd0, erros}, 32'd0);
        for (int k = 12; k <= 16; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
            check("open_window", {31'd0, aberto}, (k <= 15) ? 32'd1 : 32'd0);
        end

        // Wrong pulses at 2, 5, 8; lockout 9..16; correct at 12 ignored
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        for (int cyc = 0; cyc <= 17; cyc++) begin
            int nx;
            int exp_er;
            cycle(1'b1, (cyc == 12), (cyc == 2 || cyc == 5 || cyc == 8), 1'b0, 6'd0);
            nx = cyc + 1;
            exp_er = (nx < 3) ? 0 : (nx < 6) ? 1 : (nx < 9) ? 2 : (nx <= 16) ? 3 : 0;
            check("lock_bloq", {31'd0, bloqueado}, (nx >= 9 && nx <= 16) ? 32'd1 : 32'd0);
            check("lock_erros", {29'd0, erros}, exp_er);
            check("lock_aberto", {31'd0, aberto}, 32'd0);
        end

        // Two wrong, then correct, then one wrong after closing
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
        check("two_err", {29'd0, erros}, 32'd2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        check("reopen", {31'd0, aberto}, 32'd1);
        check("reopen_erros", {29'd0, erros}, 32'd0);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        check("closed_again", {31'd0, aberto}, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
        check("later_err", {29'd0, erros}, 32'd1);
        check("later_nolock", {31'd0, bloqueado}, 32'd0);

        // Both pulses together count as wrong
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
        check("both_erros", {29'd0, erros}, 32'd2);
        check("both_aberto", {31'd0, aberto}, 32'd0);

        // Password change attempt while open, then while closed
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 6'b000111);
`ifdef PASSWORD_CHANGE_EN
        check("chg_open", {26'd0, senha_ref}, 32'h07);
`else
        check("chg_open", {26'd0, senha_ref}, 32'h2A);
`endif
        check("chg_still_open", {31'd0, aberto}, 32'd1);
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 6'b110011);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'b110011);
`ifdef PASSWORD_CHANGE_EN
        check("chg_closed", {26'd0, senha_ref}, 32'h07);
`else
        check("chg_closed", {26'd0, senha_ref}, 32'h2A);
`endif

        // Reset during the 4th lockout cycle
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
        check("pre_rst_bloq", {31'd0, bloqueado}, 32'd1);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_now_bloq", {31'd0, bloqueado}, 32'd0);
        check("rst_now_erros", {29'd0, erros}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        check("post_rst_open", {31'd0, aberto}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit c;
            bit e;
            bit t;
            r = ($urandom_range(0, 499) != 0);
            c = ($urandom_range(0, 99) < 15);
            e = ($urandom_range(0, 99) < 12);
            t = ($urandom_range(0, 3) == 0) ? ~trocar : trocar;
            cycle(r, c, e, t, 6'($urandom));
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_fechadura.md
CONTROLE_FECHADURA -- requirements
Module: controle_fechadura

Interface
REQ-001 The block SHALL have the following parameters:
- MAX_TENTATIVAS, default 3, wrong attempts before lockout (range 1..7).
- T_ABERTO, default 50_000_000, cycles the lock stays open.
- T_BLOQUEIO, default 250_000_000, cycles of lockout.
- SENHA_INICIAL, default 6'b101010, stored password after reset.

REQ-002 The block SHALL have the following ports:
- clk, input, 1, single system clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- senha_correta, input, 1, one-cycle pulse from comparador_6bits: match.
- senha_errada, input, 1, one-cycle pulse from comparador_6bits: mismatch.
- trocar_btn, input, 1, raw level; the block detects its rising edge internally.
- senha_nova, input, 6, candidate new password (switches).
- senha_ref, output, 6, stored password; drives comparator input B.
- aberto, output, 1, lock open.
- bloqueado, output, 1, lockout active.
- erros, output, 3, current wrong-attempt count.

Function
REQ-003 FSM states SHALL be FECHADO, ABERTO and BLOQUEIO; all outputs registered.
- REQ-004 FECHADO + senha_correta: next cycle ABERTO, aberto=1, erros=0, timer loaded with T_ABERTO-1.
- REQ-005 FECHADO + senha_errada with erros+1 < MAX_TENTATIVAS: next cycle erros=erros+1, state unchanged.
- REQ-006 FECHADO + senha_errada with erros+1 == MAX_TENTATIVAS: next cycle BLOQUEIO, bloqueado=1, erros=MAX_TENTATIVAS, timer loaded with T_BLOQUEIO-1.
- REQ-007 Both pulses in the same cycle SHALL be treated as senha_errada.
- REQ-008 ABERTO: timer decrements every cycle; at timer==0, next cycle FECHADO, aberto=0; aberto SHALL be high for exactly T_ABERTO cycles.
- REQ-009 ABERTO: senha_correta and senha_errada SHALL be ignored (no count change, no timer reload).
- REQ-010 BLOQUEIO: all pulses and trocar_btn ignored; at timer==0, next cycle FECHADO, bloqueado=0, erros=0; bloqueado high for exactly T_BLOQUEIO cycles.
- REQ-011 The timer SHALL be $clog2(max(T_ABERTO,T_BLOQUEIO)) bits wide, unsigned, and never wrap (it holds at 0 outside ABERTO/BLOQUEIO).
- REQ-012 trocar_btn edge detection SHALL use one register (previous level); an edge SHALL be recognised only when the level was 0 in the previous cycle and is 1 now.
- REQ-013 aberto and bloqueado SHALL never be high simultaneously.

Reset
REQ-014 rst_n low SHALL immediately force FECHADO, aberto=0, bloqueado=0, erros=0, timer=0, senha_ref=SENHA_INICIAL, and edge register=0.
- REQ-015 Reset asserted mid-ABERTO or mid-BLOQUEIO SHALL abort the state with no residual count; the first post-reset pulse is evaluated as in FECHADO.

Configuration
REQ-016 Macro PASSWORD_CHANGE_EN defined: a trocar_btn rising edge while in ABERTO SHALL load senha_ref<=senha_nova next cycle; the state and timer SHALL be unaffected.
- REQ-017 PASSWORD_CHANGE_EN undefined: senha_ref SHALL be constant SENHA_INICIAL; trocar_btn and senha_nova SHALL be present but ignored, with no edge register synthesised.

Structure
REQ-018 The shared package fechadura_pkg SHALL hold the state enum (FECHADO/ABERTO/BLOQUEIO) and the default SENHA_INICIAL constant.
- REQ-019 The countdown SHALL be one sub-module, temporizador (load, value, zero flag); the remainder is flat.

Verification (MAX_TENTATIVAS=3, T_ABERTO=5, T_BLOQUEIO=8)
REQ-020 Correct pulse at cycle 10 -> aberto high cycles 11..15, low at 16; erros=0.
- REQ-021 Three errada pulses at cycles 2, 5, 8 -> erros 1, 2, then bloqueado high cycles 9..16; a correta pulse at cycle 12 is ignored; erros=0 at cycle 17.
- REQ-022 Two errada pulses, then correta -> aberto high, erros=0; one later errada -> erros=1 (no lockout).
- REQ-023 Correta and errada pulsed in the same cycle -> erros increments; aberto stays 0.
- REQ-024 With PASSWORD_CHANGE_EN, senha_nova=6'b000111 and a trocar_btn edge while aberto -> senha_ref=6'b000111 next cycle. The same edge while in FECHADO -> senha_ref is unchanged. Without the macro -> senha_ref stays 6'b101010.
- REQ-025 rst_n pulled low at cycle 4 of BLOQUEIO -> bloqueado=0, erros=0 immediately; the next correta after release opens the lock.
